axis_fifo_reader: RTL and testbench



---
 rtl/axis_fifo_reader.sv | 159 +++++++++++++++
 tb/tb_axis_fifo_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : axis_fifo_reader
// Purpose : AXI4-Stream master that drains a 1-cycle-latency FIFO read port
//           into fixed-length TLAST packets through a 2-entry skid buffer.
//           Define AXIS_READER_TKEEP_EN to add cfg_last_keep / m_axis_tkeep.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module axis_fifo_reader #(
   parameter int FIFO_WIDTH = 64,
   parameter int LEN_BITS   = 16
) (
   input  logic                    fifo_clk,
   input  logic                    fifo_rstn,
   input  logic                    cfg_start,
   input  logic [LEN_BITS-1:0]     cfg_len,
`ifdef AXIS_READER_TKEEP_EN
   input  logic [FIFO_WIDTH/8-1:0] cfg_last_keep,
   output logic [FIFO_WIDTH/8-1:0] m_axis_tkeep,
`endif
   output logic                    fifo_ren,
   input  logic [FIFO_WIDTH-1:0]   fifo_out,
   input  logic                    fifo_empty,
   output logic                    m_axis_tvalid,
   output logic [FIFO_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [LEN_BITS-1:0]   r_len_q;
   logic [LEN_BITS-1:0]   r_req_cnt;
   logic [LEN_BITS-1:0]   r_beat_cnt;
   logic                  r_inflight;
   logic [1:0]            r_occ;
   logic [FIFO_WIDTH-1:0] r_head;
   logic [FIFO_WIDTH-1:0] r_tail;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_pop;
   logic                  w_ren;
   logic [1:0]            w_fill;
   logic [LEN_BITS-1:0]   w_last_idx;

   // Reads already in flight count against buffer space so the buffer cannot overflow.
   assign w_fill     = r_occ + {1'b0, r_inflight};
   assign w_pop      = m_axis_tvalid & m_axis_tready;
   assign w_ren      = (r_state == S_RUN) & ~fifo_empty & (r_req_cnt < r_len_q)
                     & ((w_fill < 2'd2) | w_pop);
   assign w_last_idx = r_len_q - 1'b1;

   assign fifo_ren      = w_ren;
   assign m_axis_tvalid = (r_occ != 2'd0);
   assign m_axis_tdata  = r_head;
   assign m_axis_tlast  = m_axis_tvalid & (r_beat_cnt == w_last_idx);
   assign busy          = r_busy;
   assign done          = r_done;

`ifdef AXIS_READER_TKEEP_EN
   logic [FIFO_WIDTH/8-1:0] r_last_keep;

   assign m_axis_tkeep = !m_axis_tvalid ? '0 : (m_axis_tlast ? r_last_keep : '1);
`endif

   always_ff @(posedge fifo_clk) begin
      if (!fifo_rstn) begin
         r_state    <= S_IDLE;
         r_len_q    <= '0;
         r_req_cnt  <= '0;
         r_beat_cnt <= '0;
         r_inflight <= 1'b0;
         r_occ      <= 2'd0;
         r_head     <= '0;
         r_tail     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef AXIS_READER_TKEEP_EN
         r_last_keep <= '0;
`endif
      end else begin
         r_inflight <= w_ren;
         if (w_ren) r_req_cnt <= r_req_cnt + 1'b1;
         if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;

         // Head always presents the oldest word; tail only fills when head is stalled.
         case (r_occ)
            2'd0: begin
               if (r_inflight) begin
                  r_head <= fifo_out;
                  r_occ  <= 2'd1;
               end
            end
            2'd1: begin
               if (r_inflight && w_pop) begin
                  r_head <= fifo_out;
               end else if (r_inflight) begin
                  r_tail <= fifo_out;
                  r_occ  <= 2'd2;
               end else if (w_pop) begin
                  r_occ  <= 2'd0;
               end
            end
            default: begin
               if (w_pop) begin
                  r_head <= r_tail;
                  if (r_inflight) r_tail <= fifo_out;
                  else            r_occ  <= 2'd1;
               end
            end
         endcase

         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  r_req_cnt  <= '0;
                  r_beat_cnt <= '0;
`ifdef AXIS_READER_TKEEP_EN
                  r_last_keep <= cfg_last_keep;
`endif
                  if (cfg_len != '0) begin
                     r_len_q <= cfg_len;
                     r_busy  <= 1'b1;
                     r_state <= S_RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (r_req_cnt == r_len_q) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_pop && m_axis_tlast) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_axis_fifo_reader
// Purpose : Self-checking bench for axis_fifo_reader with a FIFO model and
//           a beat scoreboard.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_axis_fifo_reader;
   localparam int W  = 64;
   localparam int LB = 16;
   localparam int KW = W / 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cfg_start;
   logic [LB-1:0] cfg_len;
   logic          fifo_ren;
   logic [W-1:0]  fifo_out;
   logic          fifo_empty;
   logic          tvalid;
   logic [W-1:0]  tdata;
   logic          tlast;
   logic          tready;
   logic          busy;
   logic          done;
`ifdef AXIS_READER_TKEEP_EN
   logic [KW-1:0] cfg_last_keep = 8'h0F;
   logic [KW-1:0] tkeep;
`endif

   always #5 clk = ~clk;

   axis_fifo_reader #(.FIFO_WIDTH(W), .LEN_BITS(LB)) dut (
      .fifo_clk      (clk),
      .fifo_rstn     (rstn),
      .cfg_start     (cfg_start),
      .cfg_len       (cfg_len),
`ifdef AXIS_READER_TKEEP_EN
      .cfg_last_keep (cfg_last_keep),
      .m_axis_tkeep  (tkeep),
`endif
      .fifo_ren      (fifo_ren),
      .fifo_out      (fifo_out),
      .fifo_empty    (fifo_empty),
      .m_axis_tvalid (tvalid),
      .m_axis_tdata  (tdata),
      .m_axis_tlast  (tlast),
      .m_axis_tready (tready),
      .busy          (busy),
      .done          (done)
   );

   // FIFO model: registered read data one cycle after an accepted read, flushed on reset.
   logic [W-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (!rstn) rd_ptr <= wr_ptr;
      else if (fifo_ren && !fifo_empty) begin
         fifo_out <= mem[rd_ptr % 64];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int           len;
      int           prefill;
      int           late_n;
      int           late_at;
      int           rdy;
      logic [W-1:0] base;
      int           exp_beats;
      int           exp_ren;
      int           exp_lat;
      int           exp_done_k;
   } vec_t;

   int checks = 0;
   int passes = 0;
   int ren_cnt = 0, hs_cnt = 0, done_cnt = 0, valid_cnt = 0;
   bit s_valid, s_done;
   bit prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic         prev_last;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_word(input logic [W-1:0] d, input logic last);
      exp_t e;
      mem[wr_ptr % 64] = d;
      wr_ptr++;
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   // One clock: sample/check at the falling edge, return 1ns after the rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      s_valid = tvalid;
      s_done  = done;
      if (done)   done_cnt++;
      if (tvalid) valid_cnt++;
      if (fifo_ren) begin
         ren_cnt++;
         chk("ren_while_empty", 64'(fifo_empty), 64'd0);
      end
      if (prev_stall && rstn) begin
         chk("hold_valid", 64'(tvalid), 64'd1);
         chk("hold_data", tdata, prev_data);
         chk("hold_last", 64'(tlast), 64'(prev_last));
      end
      if (tvalid && tready && rstn) begin
         hs_cnt++;
         if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("beat_data", tdata, e.data);
            chk("beat_last", 64'(tlast), 64'(e.last));
`ifdef AXIS_READER_TKEEP_EN
            chk("beat_keep", 64'(tkeep), e.last ? 64'(cfg_last_keep) : 64'({KW{1'b1}}));
`endif
         end
      end
      prev_stall = rstn && tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int r0, h0, d0, fv, dk, k;
      bit fin;
      r0 = ren_cnt; h0 = hs_cnt; d0 = done_cnt;
      fv = 0; dk = 0; k = 0; fin = 1'b0;
      for (int i = 0; i < v.prefill; i++)
         push_word((v.base != 0) ? v.base + W'(i) : {$urandom(), $urandom()}, i == v.len - 1);
      cfg_len   = LB'(v.len);
      cfg_start = 1'b1;
      tready    = 1'b1;
      step();
      cfg_start = 1'b0;
      while (!fin && k < 300) begin
         if (v.late_n > 0 && k == v.late_at) begin
            chk("stall_busy", 64'(busy), 64'd1);
            chk("stall_valid", 64'(tvalid), 64'd0);
            chk("stall_ren", 64'(fifo_ren), 64'd0);
            for (int i = 0; i < v.late_n; i++)
               push_word({$urandom(), $urandom()}, v.prefill + i == v.len - 1);
         end
         case (v.rdy)
            0:       tready = 1'b1;
            1:       tready = (k % 2 == 0);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         step();
         k++;
         if (s_valid && fv == 0) fv = k;
         if (s_done) begin
            dk  = k;
            fin = 1'b1;
         end
      end
      chk("timeout", 64'(fin), 64'd1);
      tready = 1'b1;
      repeat (3) step();
      chk("beat_count", 64'(hs_cnt - h0), 64'(v.exp_beats));
      chk("ren_count", 64'(ren_cnt - r0), 64'(v.exp_ren));
      chk("done_count", 64'(done_cnt - d0), 64'd1);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      if (v.exp_lat != 0)    chk("first_valid_cycle", 64'(fv), 64'(v.exp_lat));
      if (v.exp_done_k != 0) chk("done_cycle", 64'(dk), 64'(v.exp_done_k));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
      chk({tag, "_tlast"}, 64'(tlast), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_tdata"}, tdata, 64'd0);
      chk({tag, "_ren"}, 64'(fifo_ren), 64'd0);
   endtask

   vec_t vecs [6];

   initial begin
      int r0, h0, d0, v0, k;
      vecs[0] = '{len:4, prefill:4, late_n:0, late_at:0,  rdy:0, base:64'h10, exp_beats:4, exp_ren:4, exp_lat:3, exp_done_k:7};
      vecs[1] = '{len:8, prefill:8, late_n:0, late_at:0,  rdy:1, base:64'h0,  exp_beats:8, exp_ren:8, exp_lat:3, exp_done_k:0};
      vecs[2] = '{len:5, prefill:2, late_n:3, late_at:10, rdy:0, base:64'h0,  exp_beats:5, exp_ren:5, exp_lat:3, exp_done_k:0};
      vecs[3] = '{len:6, prefill:6, late_n:0, late_at:0,  rdy:2, base:64'h0,  exp_beats:6, exp_ren:6, exp_lat:3, exp_done_k:0};
      vecs[4] = '{len:1, prefill:1, late_n:0, late_at:0,  rdy:0, base:64'h0,  exp_beats:1, exp_ren:1, exp_lat:3, exp_done_k:4};
      vecs[5] = '{len:3, prefill:0, late_n:3, late_at:4,  rdy:0, base:64'h0,  exp_beats:3, exp_ren:3, exp_lat:0, exp_done_k:0};

      rstn = 1'b0; cfg_start = 1'b0; cfg_len = '0; tready = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset");
      rstn = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Zero-length packet: straight to DONE, no reads, no beats.
      r0 = ren_cnt; h0 = hs_cnt; d0 = done_cnt; v0 = valid_cnt;
      cfg_len = '0; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      step();
      chk("len0_done_next", 64'(s_done), 64'd1);
      repeat (3) step();
      chk("len0_ren", 64'(ren_cnt - r0), 64'd0);
      chk("len0_valid", 64'(valid_cnt - v0), 64'd0);
      chk("len0_done_count", 64'(done_cnt - d0), 64'd1);

      // Start pulse while running must not launch a second packet.
      r0 = ren_cnt; h0 = hs_cnt; d0 = done_cnt;
      for (int i = 0; i < 3; i++) push_word({$urandom(), $urandom()}, i == 2);
      cfg_len = 16'd3; cfg_start = 1'b1; tready = 1'b1;
      step();
      cfg_start = 1'b0;
      step();
      cfg_len = 16'd7; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      k = 0;
      while (done_cnt == d0 && k < 50) begin step(); k++; end
      repeat (5) step();
      chk("restart_beats", 64'(hs_cnt - h0), 64'd3);
      chk("restart_ren", 64'(ren_cnt - r0), 64'd3);
      chk("restart_done", 64'(done_cnt - d0), 64'd1);
      chk("restart_busy", 64'(busy), 64'd0);

      // Reset after two of six beats.
      h0 = hs_cnt;
      for (int i = 0; i < 6; i++) push_word({$urandom(), $urandom()}, i == 5);
      cfg_len = 16'd6; cfg_start = 1'b1; tready = 1'b1;
      step();
      cfg_start = 1'b0;
      k = 0;
      while (hs_cnt - h0 < 2 && k < 20) begin step(); k++; end
      chk("pre_reset_beats", 64'(hs_cnt - h0), 64'd2);
      rstn = 1'b0; tready = 1'b0;
      step();
      check_reset_outputs("midreset");
      rstn = 1'b1; tready = 1'b1;
      exp_q.delete();
      h0 = hs_cnt; d0 = done_cnt; v0 = valid_cnt;
      repeat (6) step();
      chk("post_reset_beats", 64'(hs_cnt - h0), 64'd0);
      chk("post_reset_done", 64'(done_cnt - d0), 64'd0);
      chk("post_reset_valid", 64'(valid_cnt - v0), 64'd0);
      run_vec('{len:4, prefill:4, late_n:0, late_at:0, rdy:0, base:64'h20,
                exp_beats:4, exp_ren:4, exp_lat:3, exp_done_k:7});

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
